// File: rtl/booth_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// booth_mult_ctrl_if
// Purpose : bundles the request/result signals of the radix-4 Booth
//           multiplier so requester and multiplier share one connection.
// Signals : start         request a multiply (requester -> multiplier)
//           multiplicand  signed operand M, WIDTH bits
//           multiplier    signed operand Q, WIDTH bits
//           busy          multiply in progress (multiplier -> requester)
//           done          one-cycle pulse, product valid
//           product       signed M*Q, 2*WIDTH bits, held until next start
// Modports: master = requester side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface booth_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mult_ctrl
// Purpose : sequential radix-4 (modified Booth) signed multiplier. One
//           Booth digit is retired per clock; a WIDTH-bit multiply takes
//           WIDTH/2 steps plus one edge to publish the product.
// Ports   : clk    single clock, rising edge
//           reset  synchronous, active-high; aborts any multiply in flight
//           bus    booth_mult_ctrl_if.slave (start, multiplicand,
//                  multiplier in; busy, done, product out)
// Params  : WIDTH  operand width in bits (even, >= 4)
// Macro   : BOOTH_EARLY_TERM_EN -- when defined, the multiply finishes as
//           soon as the unprocessed multiplier bits are pure sign
//           extension (every remaining Booth digit would be zero).
//           Products are identical either way; only latency changes.
// ---------------------------------------------------------------------------
module booth_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  booth_mult_ctrl_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int IW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // r_m_sh holds the sign-extended multiplicand pre-shifted by 2*i, so the
  // partial product never needs a variable shifter.
  logic [PW-1:0]    r_m_sh;
  // r_q_sh holds {Q, 1'b0} arithmetically shifted right by 2*i: bits [2:0]
  // are always the current triplet {Q[2i+1], Q[2i], Q[2i-1]}, and the whole
  // register is the sign-extended window Q[WIDTH-1:2i-1].
  logic [WIDTH:0]   r_q_sh;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [IW-1:0]    r_i;

  logic             w_accept;
  logic             w_last;
  logic             w_early;
  logic             w_finish;
  logic             w_busy;
  logic             w_done;
  logic [2:0]       w_trip;
  logic [PW-1:0]    w_m2;
  logic [PW-1:0]    w_pp;

  // Start is honoured only outside RUN; reset priority is handled in the
  // sequential blocks.
  assign w_accept = bus.start && (r_state != RUN);

  // All WIDTH/2 digits have been retired once the index reaches STEPS.
  assign w_last = (r_i == IW'(STEPS));

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining multiplier window all-zeros or all-ones: every further Booth
  // digit decodes to 0, so the accumulator already holds the product.
  assign w_early = (r_q_sh == '0) || (&r_q_sh);
`else
  assign w_early = 1'b0;
`endif

  assign w_finish = w_last || w_early;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_finish) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        // Back-to-back request goes straight into the next multiply.
        w_state_next = bus.start ? RUN : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Booth digit decode
  // -------------------------------------------------------------------------
  assign w_trip = r_q_sh[2:0];
  assign w_m2   = r_m_sh << 1;

  always_comb begin
    w_pp = '0;
    case (w_trip)
      3'b001, 3'b010: w_pp = r_m_sh;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = ~w_m2 + PW'(1);
      3'b101, 3'b110: w_pp = ~r_m_sh + PW'(1);
      default:        w_pp = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_sh    <= '0;
      r_q_sh    <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_i       <= '0;
    end else if (w_accept) begin
      r_m_sh <= {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      r_q_sh <= {bus.multiplier, 1'b0};
      r_acc  <= '0;
      r_i    <= '0;
    end else if (r_state == RUN) begin
      if (w_finish) begin
        // Publish on the edge that enters DONE.
        r_product <= r_acc;
      end else begin
        r_acc  <= r_acc + w_pp;
        r_m_sh <= r_m_sh << 2;
        r_q_sh <= {{2{r_q_sh[WIDTH]}}, r_q_sh[WIDTH:2]};
        r_i    <= r_i + IW'(1);
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
module tb_booth_mult_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  booth_mult_ctrl_if #(.WIDTH(W)) bus ();

  booth_mult_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] last_prod;
  logic [31:0] rm;
  logic [31:0] rq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] a;
    logic signed [63:0] b;
    a = {{32{m[31]}}, m};
    b = {{32{q[31]}}, q};
    return a * b;
  endfunction

  // Edges from start sampling to the done pulse.
  function automatic int ref_lat(input logic [31:0] q);
`ifdef BOOTH_EARLY_TERM_EN
    logic [32:0] qe;
    bit          uni;
    qe = {q, 1'b0};
    for (int i = 0; i < 16; i++) begin
      uni = 1'b1;
      for (int j = 2 * i; j <= 32; j++) begin
        if (qe[j] !== qe[32]) uni = 1'b0;
      end
      if (uni) return i + 1;
    end
    return 17;
`else
    return 17;
`endif
  endfunction

  // Drive one start pulse; returns just after the sampling edge.
  task automatic start_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp_prod, input bit push);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, {63'b0, bus.busy}, 64'd1);
    check({tag, "_hold"}, bus.product, last_prod);
    if (push) begin
      e.prod = exp_prod;
      e.lat  = ref_lat(q);
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for done; offset = edges already elapsed since sampling.
  task automatic wait_done(input string tag, input int offset);
    int   n;
    bit   seen;
    exp_t e;
    n    = offset;
    seen = 1'b0;
    while (n < offset + 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
    check({tag, "_sb_nonempty"}, {63'b0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(n), 64'(e.lat));
      check({tag, "_product"}, bus.product, e.prod);
      check({tag, "_busy_low"}, {63'b0, bus.busy}, 64'd0);
      last_prod = e.prod;
      $display("txn %s product=0x%h latency=%0d", tag, bus.product, n);
    end
  endtask

  // Confirm no done pulse within n edges.
  task automatic no_done(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check({tag, "_no_done"}, 64'(pulses), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("busy_done_excl", {63'b0, bus.busy & bus.done}, 64'd0);
    end
  end

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    last_prod        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_product", bus.product, 64'd0);
    reset = 1'b0;

    start_op("m7_qn3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    wait_done("m7_qn3", 0);

    start_op("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_done("min_min", 0);

    start_op("neg1_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b1);
    wait_done("neg1_neg1", 0);

    start_op("m5_q3", 32'd5, 32'd3, 64'd15, 1'b1);
    wait_done("m5_q3", 0);

    start_op("q_zero", 32'h1234_5678, 32'd0, 64'd0, 1'b1);
    wait_done("q_zero", 0);

    start_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b1);
    wait_done("min_max", 0);

    // Start pulsed again at edge 5 with other operands: must be ignored.
    start_op("ignored", 32'd1000, 32'h1234_5678, ref_mul(32'd1000, 32'h1234_5678), 1'b1);
    repeat (4) @(posedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'hDEAD_BEEF;
    bus.multiplier   = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignored", 5);
    no_done("ignored", 20);

    // Reset at edge 8 of a multiply aborts it.
    start_op("rst", 32'h0001_2345, 32'h7FFF_0001, 64'd0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_product", bus.product, 64'd0);
    reset     = 1'b0;
    last_prod = '0;
    no_done("rst", 20);

    start_op("after_rst", 32'h0001_2345, 32'h7FFF_0001, ref_mul(32'h0001_2345, 32'h7FFF_0001), 1'b1);
    wait_done("after_rst", 0);

    // Back-to-back: start held high during DONE.
    start_op("b2b_a", 32'd3, 32'd4, 64'd12, 1'b1);
    wait_done("b2b_a", 0);
    bus.start        = 1'b1;
    bus.multiplicand = 32'hFFFF_FFFE;
    bus.multiplier   = 32'd6;
    sb.push_back('{prod: 64'hFFFF_FFFF_FFFF_FFF4, lat: ref_lat(32'd6)});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_b_busy", {63'b0, bus.busy}, 64'd1);
    check("b2b_b_hold", bus.product, last_prod);
    wait_done("b2b_b", 0);

    for (int k = 0; k < 6; k++) begin
      rm = $urandom;
      rq = $urandom;
      start_op($sformatf("rand%0d", k), rm, rq, ref_mul(rm, rq), 1'b1);
      wait_done($sformatf("rand%0d", k), 0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_ctrl.md
BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (even, >= 4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new multiply; sampled only when not busy.
REQ-005 SHALL have port: multiplicand  input  WIDTH  signed two's-complement M, captured on start acceptance.
REQ-006 SHALL have port: multiplier  input  WIDTH  signed two's-complement Q, captured on start acceptance.
REQ-007 SHALL have port: busy  output  1  high while a multiply is in progress (RUN state).
REQ-008 SHALL have port: done  output  1  one-cycle pulse when product is valid.
REQ-009 SHALL have port: product  output  2*WIDTH  signed result M*Q; held until next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after final step; DONE->IDLE unconditionally, or DONE->RUN if start is high.
REQ-011 SHALL accept start only in IDLE or DONE; start while busy SHALL be ignored with no effect on captured operands or accumulator.
REQ-012 On acceptance SHALL latch M and Q, clear accumulator to 0, clear step index i to 0; product output SHALL remain unchanged until DONE.
REQ-013 In RUN, step i (0..WIDTH/2-1) SHALL form triplet {Q[2i+1], Q[2i], Q[2i-1]}, with Q[-1] = 0.
REQ-014 Triplet decode SHALL be: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-015 M SHALL be sign-extended to 2*WIDTH bits before doubling or negation; negation is two's complement over 2*WIDTH bits.
REQ-016 Partial product SHALL be shifted left by 2i and added to accumulator modulo 2^(2*WIDTH), one step per clock.
REQ-017 Without early termination, DONE SHALL be entered on the edge after step WIDTH/2-1: done high exactly WIDTH/2+1 edges after the edge that sampled start (17 for WIDTH=32).
REQ-018 On entering DONE, product SHALL be loaded with the accumulator; done SHALL be high for exactly that one cycle.
REQ-019 busy SHALL be high in RUN only; busy and done SHALL never be high together.
REQ-020 Back-to-back: start high during DONE SHALL enter RUN on the next edge with new operands; done SHALL still pulse for the completed operation.
REQ-021 Result SHALL be exact for all operand pairs including M = Q = -2^(WIDTH-1).

Reset
REQ-022 On reset high at a rising edge, state SHALL become IDLE; busy = 0, done = 0, product = 0, accumulator = 0, i = 0.
REQ-023 Reset mid-operation SHALL abort the multiply with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-024 SHALL support macro BOOTH_EARLY_TERM_EN.
REQ-025 With BOOTH_EARLY_TERM_EN defined, before executing step i in RUN, if Q[WIDTH-1:2i-1] (with Q[-1] = 0) is all-zeros or all-ones, the block SHALL skip the add and go to DONE on that edge.
REQ-026 With BOOTH_EARLY_TERM_EN defined, done SHALL occur k+1 edges after start sampling, where k is the number of executed steps; Q = 0 gives k = 0.
REQ-027 Without BOOTH_EARLY_TERM_EN, latency SHALL be fixed per REQ-017 regardless of operands.
REQ-028 Product values SHALL be identical with and without BOOTH_EARLY_TERM_EN.

Verification
REQ-029 M=7, Q=-3 -> product 0xFFFF_FFFF_FFFF_FFEB; done 17 edges after start (macro off).
REQ-030 M=Q=0x8000_0000 -> product 0x4000_0000_0000_0000; M=Q=0xFFFF_FFFF -> product 1.
REQ-031 start pulsed again at edge 5 of a multiply with different operands -> ignored; first result is correct; single done pulse.
REQ-032 reset asserted at edge 8 of a multiply -> busy=0, product=0 next cycle, no done; a fresh start then completes correctly.
REQ-033 Macro on: M=5, Q=3 -> product 15, done 3 edges after start; Q=0 -> product 0, done 1 edge after start.
REQ-034 Back-to-back 3*4 then -2*6 with start held in DONE -> products 12 then 0xFFFF_FFFF_FFFF_FFF4, two done pulses 17 edges apart.
